// File: rtl/conv_encoder_punct.sv
// K=7 802.11a convolutional encoder (g0=133o, g1=171o) with rate-dependent puncturing.
// Define TAIL_FLUSH_EN to append TAIL_LEN zero bits after the last information bit.
module conv_encoder_punct #(
    parameter int           K  = 7,
    parameter logic [K-1:0] G0 = 7'b1011011,
    parameter logic [K-1:0] G1 = 7'b1111001
`ifdef TAIL_FLUSH_EN
    ,
    parameter int           TAIL_LEN = 6
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rate,
    input  logic       start,
    input  logic       dataIn,
    input  logic       dataValid,
    input  logic       dataLast,
    output logic       dataAccept,
    output logic [1:0] vecBits,
    output logic [1:0] vecMask,
    output logic       outValid,
    input  logic       outReady,
    output logic       done
);

    localparam int SR_W = K - 1;

    typedef enum logic [1:0] {
        RATE_12 = 2'd0,
        RATE_23 = 2'd1,
        RATE_34 = 2'd2
    } rate_e;

`ifdef TAIL_FLUSH_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_TAIL    = 2'd2,
        ST_LASTOUT = 2'd3
    } state_e;

    localparam int             TW        = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam logic [TW-1:0]  TAIL_LAST = TW'(TAIL_LEN - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_LASTOUT = 2'd3
    } state_e;
`endif

    function automatic logic conv_tap(input logic [K-1:0] window, input logic [K-1:0] gen);
        return ^(window & gen);
    endfunction

    function automatic rate_e decode_rate(input logic [3:0] field);
        rate_e r;
        case (field)
            4'b0001:                             r = RATE_23;
            4'b1111, 4'b0111, 4'b1011, 4'b0011:  r = RATE_34;
            default:                             r = RATE_12;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] punct_mask(input rate_e r, input logic [1:0] pos);
        logic [1:0] m;
        case (r)
            RATE_23: m = pos[0] ? 2'b10 : 2'b11;
            RATE_34: begin
                case (pos)
                    2'd0:    m = 2'b11;
                    2'd1:    m = 2'b10;
                    2'd2:    m = 2'b01;
                    default: m = 2'b11;
                endcase
            end
            default: m = 2'b11;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] punct_next(input rate_e r, input logic [1:0] pos);
        logic [1:0] n;
        case (r)
            RATE_23: n = (pos == 2'd1) ? 2'd0 : pos + 2'd1;
            RATE_34: n = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    state_e        state_q, state_d;
    rate_e         rate_q, rate_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [1:0]    punct_q, punct_d;
    logic [1:0]    vec_bits_q, vec_bits_d;
    logic [1:0]    vec_mask_q, vec_mask_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
`ifdef TAIL_FLUSH_EN
    logic [TW-1:0] tail_q, tail_d;
`endif

    logic            accept_s;
    logic            in_bit_s;
    logic [K-1:0]    window_s;
    logic [1:0]      code_mask_s;
    logic [1:0]      code_bits_s;
    logic [SR_W-1:0] next_sr_s;
    logic [1:0]      next_punct_s;

    // Tail states feed zeros, so the encoder input is dataIn only while encoding.
    assign accept_s     = (state_q == ST_ENCODE) && (!out_valid_q || outReady);
    assign in_bit_s     = (state_q == ST_ENCODE) ? dataIn : 1'b0;
    assign window_s     = {in_bit_s, sr_q};
    assign code_mask_s  = punct_mask(rate_q, punct_q);
    assign code_bits_s  = {conv_tap(window_s, G0), conv_tap(window_s, G1)} & code_mask_s;
    assign next_sr_s    = {in_bit_s, sr_q[SR_W-1:1]};
    assign next_punct_s = punct_next(rate_q, punct_q);

    // Next-state and output-register computation for the frame controller.
    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        sr_d        = sr_q;
        punct_d     = punct_q;
        vec_bits_d  = vec_bits_q;
        vec_mask_d  = vec_mask_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
`ifdef TAIL_FLUSH_EN
        tail_d      = tail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d = ST_ENCODE;
                    rate_d  = decode_rate(rate);
                    sr_d    = '0;
                    punct_d = 2'd0;
`ifdef TAIL_FLUSH_EN
                    tail_d  = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENCODE: begin
                if (accept_s && dataValid) begin
                    vec_bits_d  = code_bits_s;
                    vec_mask_d  = code_mask_s;
                    sr_d        = next_sr_s;
                    punct_d     = next_punct_s;
                    out_valid_d = 1'b1;
                    if (dataLast) begin
`ifdef TAIL_FLUSH_EN
                        state_d = ST_TAIL;
                        tail_d  = '0;
`else
                        state_d = ST_LASTOUT;
`endif
                    end else begin
                        state_d = ST_ENCODE;
                    end
                end else if (out_valid_q && outReady) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
`ifdef TAIL_FLUSH_EN
            ST_TAIL: begin
                if (!out_valid_q || outReady) begin
                    vec_bits_d  = code_bits_s;
                    vec_mask_d  = code_mask_s;
                    sr_d        = next_sr_s;
                    punct_d     = next_punct_s;
                    out_valid_d = 1'b1;
                    if (tail_q == TAIL_LAST) begin
                        state_d = ST_LASTOUT;
                    end else begin
                        tail_d = tail_q + TW'(1);
                    end
                end else begin
                    state_d = ST_TAIL;
                end
            end
`endif
            ST_LASTOUT: begin
                if (out_valid_q && outReady) begin
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_LASTOUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rate_q      <= RATE_12;
            sr_q        <= '0;
            punct_q     <= 2'd0;
            vec_bits_q  <= 2'b00;
            vec_mask_q  <= 2'b00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef TAIL_FLUSH_EN
            tail_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            sr_q        <= sr_d;
            punct_q     <= punct_d;
            vec_bits_q  <= vec_bits_d;
            vec_mask_q  <= vec_mask_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef TAIL_FLUSH_EN
            tail_q      <= tail_d;
`endif
        end
    end

    assign dataAccept = accept_s;
    assign vecBits    = vec_bits_q;
    assign vecMask    = vec_mask_q;
    assign outValid   = out_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct with hand-computed coded pairs and masks.
// The tail-flush scenario runs only when TAIL_FLUSH_EN is defined.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rate;
    logic       start;
    logic       dataIn;
    logic       dataValid;
    logic       dataLast;
    logic       dataAccept;
    logic [1:0] vecBits;
    logic [1:0] vecMask;
    logic       outValid;
    logic       outReady;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc;
    int done_before;

    logic [1:0] got_v[$];
    logic [1:0] got_m[$];
    logic [1:0] exp_v[$];
    logic [1:0] exp_m[$];

    always #5 clk = ~clk;

    conv_encoder_punct dut (
        .clk        (clk),
        .rst        (rst),
        .rate       (rate),
        .start      (start),
        .dataIn     (dataIn),
        .dataValid  (dataValid),
        .dataLast   (dataLast),
        .dataAccept (dataAccept),
        .vecBits    (vecBits),
        .vecMask    (vecMask),
        .outValid   (outValid),
        .outReady   (outReady),
        .done       (done)
    );

    // Output collector: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (outValid && outReady) begin
            got_v.push_back(vecBits);
            got_m.push_back(vecMask);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [3:0] r);
        rate  = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rate  = 4'b0000;
    endtask

    task automatic send_bit(input logic b, input logic last, output int cycles);
        logic acc;
        acc       = 1'b0;
        cycles    = 0;
        dataValid = 1'b1;
        dataIn    = b;
        dataLast  = last;
        do begin
            @(negedge clk);
            acc = dataAccept;
            @(posedge clk); #1;
            cycles++;
        end while (!acc && cycles < 50);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        dataValid = 1'b0;
        dataLast  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   t;
        logic seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 50) begin
            @(negedge clk);
            seen = done;
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, 32'(got_v.size()), 32'(exp_v.size()));
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
            chk($sformatf("%s_vec%0d", tag, i), 32'(got_v[i]), 32'(exp_v[i]));
            chk($sformatf("%s_mask%0d", tag, i), 32'(got_m[i]), 32'(exp_m[i]));
        end
        got_v.delete();
        got_m.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        rate      = 4'b0000;
        start     = 1'b0;
        dataIn    = 1'b0;
        dataValid = 1'b0;
        dataLast  = 1'b0;
        outReady  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid",  32'(outValid),   32'd0);
        chk("rst_bits",   32'(vecBits),    32'd0);
        chk("rst_mask",   32'(vecMask),    32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_accept", 32'(dataAccept), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // R1/2 impulse response, with exact done timing
        start_frame(4'b1101);
        for (int i = 0; i < 7; i++) send_bit((i == 0), (i == 6), cyc);
        @(negedge clk);
        chk("imp_done_early", 32'(done), 32'd0);
        chk("imp_last_valid", 32'(outValid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("imp_done_pulse", 32'(done), 32'd1);
        chk("imp_valid_drop", 32'(outValid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("imp_done_once", 32'(done), 32'd0);
        @(posedge clk); #1;
        exp_v = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
        exp_m = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        check_frame("imp");

        // R3/4, nine ones
        start_frame(4'b1111);
        for (int i = 0; i < 9; i++) send_bit(1'b1, (i == 8), cyc);
        wait_done("r34");
        exp_v = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd2, 2'd1};
        exp_m = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
        check_frame("r34");

        // R2/3 impulse
        start_frame(4'b0001);
        for (int i = 0; i < 4; i++) send_bit((i == 0), (i == 3), cyc);
        wait_done("r23");
        exp_v = '{2'd3, 2'd0, 2'd3, 2'd2};
        exp_m = '{2'd3, 2'd2, 2'd3, 2'd2};
        check_frame("r23");

        // Unknown rate field falls back to R1/2
        start_frame(4'b0000);
        for (int i = 0; i < 4; i++) send_bit((i == 0), (i == 3), cyc);
        wait_done("rdef");
        exp_v = '{2'd3, 2'd1, 2'd3, 2'd3};
        exp_m = '{2'd3, 2'd3, 2'd3, 2'd3};
        check_frame("rdef");

        // Backpressure: stall five cycles after the second bit, then full throughput
        start_frame(4'b0101);
        send_bit(1'b1, 1'b0, cyc);
        send_bit(1'b1, 1'b0, cyc);
        outReady  = 1'b0;
        dataValid = 1'b1;
        dataIn    = 1'b0;
        dataLast  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_accept", 32'(dataAccept), 32'd0);
            chk("bp_valid",  32'(outValid),   32'd1);
            chk("bp_vec",    32'(vecBits),    32'd2);
            chk("bp_mask",   32'(vecMask),    32'd3);
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        send_bit(1'b0, 1'b0, cyc); chk("bp_tput2", 32'(cyc), 32'd1);
        send_bit(1'b1, 1'b0, cyc); chk("bp_tput3", 32'(cyc), 32'd1);
        send_bit(1'b0, 1'b0, cyc); chk("bp_tput4", 32'(cyc), 32'd1);
        send_bit(1'b0, 1'b1, cyc); chk("bp_tput5", 32'(cyc), 32'd1);
        wait_done("bp");
        exp_v = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1};
        exp_m = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        check_frame("bp");

`ifdef TAIL_FLUSH_EN
        // Tail flush: last data bit is 1, so the tail carries its impulse response
        start_frame(4'b1111);
        for (int i = 0; i < 10; i++) send_bit((i == 9), (i == 9), cyc);
        dataIn = 1'b1;
        wait_done("tail");
        dataIn = 1'b0;
        exp_v = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                  2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};
        exp_m = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1,
                  2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
        check_frame("tail");
`endif

        // Reset mid-frame, then a clean frame from zero state
        done_before = done_cnt;
        start_frame(4'b1101);
        send_bit(1'b1, 1'b0, cyc);
        send_bit(1'b1, 1'b0, cyc);
        send_bit(1'b0, 1'b0, cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_valid",  32'(outValid),   32'd0);
        chk("mrst_done",   32'(done),       32'd0);
        chk("mrst_accept", 32'(dataAccept), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_done", 32'(done_cnt - done_before), 32'd0);
        got_v.delete();
        got_m.delete();
        start_frame(4'b1101);
        for (int i = 0; i < 7; i++) send_bit((i == 0), (i == 6), cyc);
        wait_done("post");
        exp_v = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
        exp_m = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        check_frame("post");
        chk("post_done_count", 32'(done_cnt - done_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
- Transmit-side K=7 convolutional encoder (802.11a, g0=133o, g1=171o) with rate-dependent puncturing.
- Produces the coded A/B pairs that the receive-side branch-metric/Viterbi path consumes.
- Accepts one information bit per handshake and emits one registered 2-bit vector plus a keep mask per input bit.
- Punctured positions are flagged so the downstream mapper/interleaver drops them.

Parameters:
- K, 7, constraint length; shift register holds K-1 = 6 bits.
- G0, 7'b1011011, generator for output A, MSB = current input, then D1..D6.
- G1, 7'b1111001, generator for output B, same tap ordering.
- TAIL_LEN, 6, number of zero tail bits appended (used only with TAIL_FLUSH_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rate  in  4  802.11a RATE field; sampled only on start.
- start  in  1  one-cycle pulse in IDLE begins a frame.
- dataIn  in  1  information bit.
- dataValid  in  1  dataIn valid.
- dataLast  in  1  qualifies the final information bit of the frame.
- dataAccept  out  1  encoder takes dataIn this cycle when dataValid=1.
- vecBits  out  2  coded pair: [1] = A (G0), [0] = B (G1); punctured bit forced to 0.
- vecMask  out  2  keep flags aligned with vecBits; 1 = transmit, 0 = punctured.
- outValid  out  1  vecBits/vecMask valid.
- outReady  in  1  downstream accepts the output register.
- done  out  1  one-cycle pulse when the frame's final output is accepted.

Behaviour:
- Reset: state=IDLE; shift register=0; puncture counter=0; vecBits=0; vecMask=0; outValid=0; done=0; dataAccept=0.
  - rst mid-frame aborts immediately, with no partial done.
- Rate decode, latched at start:
  - 1101, 0101, 1001 -> R1/2.
  - 0001 -> R2/3.
  - 1111, 0111, 1011, 0011 -> R3/4.
  - Any other value -> R1/2.
- States:
  - IDLE: start -> ENCODE; clear shift register and puncture counter; latch rate. start in any other state is ignored.
  - ENCODE: dataAccept = (!outValid || outReady). Each accepted bit:
    - A = ^({dataIn, sr} & G0), B = ^({dataIn, sr} & G1).
    - sr <= {dataIn, sr[5:1]}; output register loaded next edge; outValid=1.
    - Accepted bit with dataLast=1 -> TAIL if TAIL_FLUSH_EN, else LASTOUT.
  - TAIL: internally injects zero input bits under the same output-stall rule.
    - Tail counter 0..TAIL_LEN-1.
    - After the final tail bit is loaded -> LASTOUT.
  - LASTOUT: wait for outValid && outReady; then pulse done, outValid=0 -> IDLE.
- Latency: bit accepted at edge n -> vecBits valid from edge n (registered), held stable while outValid && !outReady.
- Puncture counter advances once per loaded output, including tail bits.
  - R1/2: mask always 11.
  - R2/3: counter mod 2; pos0 -> 11, pos1 -> 10.
  - R3/4: counter mod 3; pos0 -> 11, pos1 -> 10, pos2 -> 01.
  - Wraps to 0; reset to 0 at start.
- Back-to-back: a new bit may load in the same cycle the previous output is accepted, giving full throughput of one bit per clock.
- dataValid while dataAccept=0 is held by the upstream; dataIn is never sampled in IDLE, TAIL, or LASTOUT.
- start and dataValid in the same IDLE cycle: start takes effect; data is accepted from the next cycle.

Optional Feature:
- Macro: TAIL_FLUSH_EN.
- Defined: after dataLast the encoder appends TAIL_LEN zero bits, returning the state to 0. Total outputs = N + 6.
- Undefined: no TAIL state; ENCODE -> LASTOUT directly. Total outputs = N; tail bits are the upstream's responsibility. Shift register still clears on start.

Test Plan:
- R1/2 impulse: rate=1101, bits 1,0,0,0,0,0,0 (last on 7th), outReady=1 -> vecBits {A,B} = 11,01,11,11,00,10,11; mask always 11; done one cycle after 7th output (no TAIL_FLUSH_EN).
- R3/4 mask sequence: rate=1111, 9 bits of 1 -> vecMask = 11,10,01 repeated 3 times; punctured bit positions read 0.
- R2/3 mask and unknown rate: rate=0001, 4 bits -> masks 11,10,11,10. rate=0000 -> all masks 11.
- Backpressure: hold outReady=0 for 5 cycles mid-frame -> dataAccept=0, vecBits/vecMask/outValid stable; on release, throughput resumes at one bit per clock with no loss or duplication.
- TAIL_FLUSH_EN: 10 random bits -> 16 outputs; final 6 inputs are zero; shift register = 0 at done; puncture pattern continues through the tail.
- Reset mid-frame: assert rst after 3 accepted bits -> next edge outValid=0, done=0, state IDLE; a subsequent frame matches golden output from a zero state.
